// File: rtl/wb_ctrl_if.sv
// -----------------------------------------------------------------------------
// wb_ctrl_if -- bundle of the writeback controller's bus-side signals.
//   ALU source : alu_valid/alu_rd/alu_data in, alu_ready out
//   LSU source : lsu_valid/lsu_rd/lsu_data in, lsu_ready out
//   Issue      : issue_valid/issue_rd in (marks a register pending)
//   Regfile    : rd_wren/rd_addr/rd_data out (registered write port)
//   Scoreboard : busy_o out, bit i = register i awaiting writeback
// master = the surrounding pipeline, slave = wb_ctrl.
// -----------------------------------------------------------------------------
interface wb_ctrl_if;
    logic        alu_valid;
    logic [4:0]  alu_rd;
    logic [31:0] alu_data;
    logic        alu_ready;
    logic        lsu_valid;
    logic [4:0]  lsu_rd;
    logic [31:0] lsu_data;
    logic        lsu_ready;
    logic        issue_valid;
    logic [4:0]  issue_rd;
    logic        rd_wren;
    logic [4:0]  rd_addr;
    logic [31:0] rd_data;
    logic [31:0] busy_o;

    modport master (
        output alu_valid, alu_rd, alu_data,
        output lsu_valid, lsu_rd, lsu_data,
        output issue_valid, issue_rd,
        input  alu_ready, lsu_ready,
        input  rd_wren, rd_addr, rd_data, busy_o
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data,
        input  lsu_valid, lsu_rd, lsu_data,
        input  issue_valid, issue_rd,
        output alu_ready, lsu_ready,
        output rd_wren, rd_addr, rd_data, busy_o
    );
endinterface

// File: rtl/wb_ctrl.sv
// -----------------------------------------------------------------------------
// wb_ctrl -- register-file writeback controller.
// Two result sources (ALU, LSU) each feed a 2-entry {rd, data} FIFO. A
// round-robin arbiter pops at most one head per cycle onto a registered
// register-file write port. A pending-write scoreboard is set on issue and
// cleared on commit.
//   clk_i  : clock, rising edge
//   rst_ni : asynchronous active-low reset
//   bus    : wb_ctrl_if.slave (source handshakes, issue, write port, busy_o)
// -----------------------------------------------------------------------------
module wb_ctrl (
    input  logic     clk_i,
    input  logic     rst_ni,
    wb_ctrl_if.slave bus
);

    logic [4:0]  r_alu_rd   [2];
    logic [31:0] r_alu_data [2];
    logic        r_alu_wp;
    logic        r_alu_rp;
    logic [1:0]  r_alu_cnt;

    logic [4:0]  r_lsu_rd   [2];
    logic [31:0] r_lsu_data [2];
    logic        r_lsu_wp;
    logic        r_lsu_rp;
    logic [1:0]  r_lsu_cnt;

    // Set when the LSU took the most recent grant; reset value makes ALU win
    // the first tie.
    logic        r_last_lsu;
    logic        r_wren;
    logic [4:0]  r_addr;
    logic [31:0] r_data;
    logic [31:0] r_busy;

    logic        w_alu_ready;
    logic        w_lsu_ready;
    logic        w_alu_push;
    logic        w_lsu_push;
    logic        w_alu_pop;
    logic        w_lsu_pop;
    logic        w_grant;
    logic [4:0]  w_head_rd;
    logic [31:0] w_head_data;
    logic [31:0] w_busy_nxt;

    // Ready depends on registered occupancy only.
    assign w_alu_ready = (r_alu_cnt < 2'd2);
    assign w_lsu_ready = (r_lsu_cnt < 2'd2);
    assign w_alu_push  = bus.alu_valid & w_alu_ready;
    assign w_lsu_push  = bus.lsu_valid & w_lsu_ready;

    always_comb begin
        w_alu_pop   = (r_alu_cnt != 2'd0) && ((r_lsu_cnt == 2'd0) || r_last_lsu);
        w_lsu_pop   = (r_lsu_cnt != 2'd0) && !w_alu_pop;
        w_grant     = w_alu_pop | w_lsu_pop;
        w_head_rd   = w_lsu_pop ? r_lsu_rd[r_lsu_rp]   : r_alu_rd[r_alu_rp];
        w_head_data = w_lsu_pop ? r_lsu_data[r_lsu_rp] : r_alu_data[r_alu_rp];
    end

    // Clear is applied before set so an issue to the committing register wins.
    always_comb begin
        w_busy_nxt = r_busy;
        if (w_grant && (w_head_rd != '0)) begin
            w_busy_nxt[w_head_rd] = 1'b0;
        end
        if (bus.issue_valid && (bus.issue_rd != '0)) begin
            w_busy_nxt[bus.issue_rd] = 1'b1;
        end
        w_busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            r_alu_rd   <= '{default: '0};
            r_alu_data <= '{default: '0};
            r_alu_wp   <= 1'b0;
            r_alu_rp   <= 1'b0;
            r_alu_cnt  <= '0;
            r_lsu_rd   <= '{default: '0};
            r_lsu_data <= '{default: '0};
            r_lsu_wp   <= 1'b0;
            r_lsu_rp   <= 1'b0;
            r_lsu_cnt  <= '0;
            r_last_lsu <= 1'b1;
            r_wren     <= 1'b0;
            r_addr     <= '0;
            r_data     <= '0;
            r_busy     <= '0;
        end else begin
            if (w_alu_push) begin
                r_alu_rd[r_alu_wp]   <= bus.alu_rd;
                r_alu_data[r_alu_wp] <= bus.alu_data;
                r_alu_wp             <= ~r_alu_wp;
            end
            if (w_alu_pop) begin
                r_alu_rp <= ~r_alu_rp;
            end
            r_alu_cnt <= r_alu_cnt + 2'(w_alu_push) - 2'(w_alu_pop);

            if (w_lsu_push) begin
                r_lsu_rd[r_lsu_wp]   <= bus.lsu_rd;
                r_lsu_data[r_lsu_wp] <= bus.lsu_data;
                r_lsu_wp             <= ~r_lsu_wp;
            end
            if (w_lsu_pop) begin
                r_lsu_rp <= ~r_lsu_rp;
            end
            r_lsu_cnt <= r_lsu_cnt + 2'(w_lsu_push) - 2'(w_lsu_pop);

            // An x0 entry is consumed and counts for round-robin, but
            // produces no write and leaves the write port contents alone.
            r_wren <= w_grant && (w_head_rd != '0);
            if (w_grant) begin
                r_last_lsu <= w_lsu_pop;
                if (w_head_rd != '0) begin
                    r_addr <= w_head_rd;
                    r_data <= w_head_data;
                end
            end

            r_busy <= w_busy_nxt;
        end
    end

    assign bus.alu_ready = w_alu_ready;
    assign bus.lsu_ready = w_lsu_ready;
    assign bus.rd_wren   = r_wren;
    assign bus.rd_addr   = r_addr;
    assign bus.rd_data   = r_data;
    assign bus.busy_o    = r_busy;

endmodule

// File: tb/tb_wb_ctrl.sv
// -----------------------------------------------------------------------------
// tb_wb_ctrl -- directed self-checking bench for wb_ctrl.
// Inputs change 1 time unit after a rising edge; outputs are checked shortly
// after the edge, once registered state has settled.
// -----------------------------------------------------------------------------
module tb_wb_ctrl;

    logic clk = 1'b0;
    logic rst_ni = 1'b0;
    int   n_vec = 0;
    int   n_err = 0;

    wb_ctrl_if bus ();

    wb_ctrl dut (
        .clk_i  (clk),
        .rst_ni (rst_ni),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.alu_valid   = 1'b0;
        bus.alu_rd      = '0;
        bus.alu_data    = '0;
        bus.lsu_valid   = 1'b0;
        bus.lsu_rd      = '0;
        bus.lsu_data    = '0;
        bus.issue_valid = 1'b0;
        bus.issue_rd    = '0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst_ni = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_ni = 1'b1;
    endtask

    task automatic test_reset();
        idle_inputs();
        rst_ni = 1'b0;
        step();
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL reset_wren got=%b exp=0", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd0) begin n_err++; $display("FAIL reset_addr got=%0d exp=0", bus.rd_addr); end
        n_vec++; if (bus.rd_data !== 32'd0) begin n_err++; $display("FAIL reset_data got=%h exp=0", bus.rd_data); end
        n_vec++; if (bus.busy_o !== 32'd0) begin n_err++; $display("FAIL reset_busy got=%h exp=0", bus.busy_o); end
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL reset_alu_ready got=%b exp=1", bus.alu_ready); end
        n_vec++; if (bus.lsu_ready !== 1'b1) begin n_err++; $display("FAIL reset_lsu_ready got=%b exp=1", bus.lsu_ready); end
        rst_ni = 1'b1;
    endtask

    task automatic test_single();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd5;
        step();
        bus.issue_valid = 1'b0;
        n_vec++; if (bus.busy_o !== 32'h20) begin n_err++; $display("FAIL single_busy_set got=%h exp=00000020", bus.busy_o); end
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();  // edge k: accepted
        bus.alu_valid = 1'b0;
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL single_wren_k got=%b exp=0", bus.rd_wren); end
        n_vec++; if (bus.busy_o !== 32'h20) begin n_err++; $display("FAIL single_busy_k got=%h exp=00000020", bus.busy_o); end
        step();  // edge k+1: granted
        n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL single_wren got=%b exp=1", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd5) begin n_err++; $display("FAIL single_addr got=%0d exp=5", bus.rd_addr); end
        n_vec++; if (bus.rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data got=%h exp=deadbeef", bus.rd_data); end
        n_vec++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL single_busy_clr got=%h exp=0", bus.busy_o); end
        step();
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL single_wren_after got=%b exp=0", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd5) begin n_err++; $display("FAIL single_addr_hold got=%0d exp=5", bus.rd_addr); end
        n_vec++; if (bus.rd_data !== 32'hDEADBEEF) begin n_err++; $display("FAIL single_data_hold got=%h exp=deadbeef", bus.rd_data); end
    endtask

    task automatic test_x0();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'hFFFFFFFF;
        step();
        idle_inputs();
        n_vec++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL x0_busy_issue got=%h exp=0", bus.busy_o); end
        for (int i = 0; i < 2; i++) begin
            step();
            n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL x0_wren[%0d] got=%b exp=0", i, bus.rd_wren); end
            n_vec++; if (bus.busy_o !== 32'h0) begin n_err++; $display("FAIL x0_busy[%0d] got=%h exp=0", i, bus.busy_o); end
        end
    endtask

    task automatic test_simultaneous();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd1; bus.alu_data = 32'h11;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd2; bus.lsu_data = 32'h22;
        step();  // edge 1: first pair queued
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL sim_wren_e1 got=%b exp=0", bus.rd_wren); end
        step();  // edge 2: second pair queued, ALU wins tie
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        n_vec++; if (bus.lsu_ready !== 1'b0) begin n_err++; $display("FAIL sim_lsu_full got=%b exp=0", bus.lsu_ready); end
        for (int i = 0; i < 4; i++) begin
            if (i > 0) step();
            n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL sim_wren[%0d] got=%b exp=1", i, bus.rd_wren); end
            n_vec++; if (bus.rd_addr !== ((i % 2 == 0) ? 5'd1 : 5'd2)) begin n_err++; $display("FAIL sim_addr[%0d] got=%0d exp=%0d", i, bus.rd_addr, (i % 2 == 0) ? 1 : 2); end
            n_vec++; if (bus.rd_data !== ((i % 2 == 0) ? 32'h11 : 32'h22)) begin n_err++; $display("FAIL sim_data[%0d] got=%h exp=%h", i, bus.rd_data, (i % 2 == 0) ? 32'h11 : 32'h22); end
        end
        step();
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL sim_wren_end got=%b exp=0", bus.rd_wren); end
    endtask

    task automatic test_same_edge();
        do_reset();
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd7;
        step();  // edge 1: queued + busy[7] set
        bus.alu_valid = 1'b0;
        n_vec++; if (bus.busy_o !== 32'h80) begin n_err++; $display("FAIL same_busy_e1 got=%h exp=00000080", bus.busy_o); end
        step();  // edge 2: commit of 7 and a new issue of 7
        bus.issue_valid = 1'b0;
        n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL same_wren got=%b exp=1", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd7) begin n_err++; $display("FAIL same_addr got=%0d exp=7", bus.rd_addr); end
        n_vec++; if (bus.busy_o !== 32'h80) begin n_err++; $display("FAIL same_busy_e2 got=%h exp=00000080", bus.busy_o); end
        step();
        n_vec++; if (bus.busy_o !== 32'h80) begin n_err++; $display("FAIL same_busy_e3 got=%h exp=00000080", bus.busy_o); end
    endtask

    task automatic drive_alu3();
        for (int i = 0; i < 3; i++) begin
            logic acc = 1'b0;
            bus.alu_valid = 1'b1; bus.alu_rd = 5'd3; bus.alu_data = 32'hA1 + 32'(i);
            for (int c = 0; c < 20 && !acc; c++) begin
                acc = bus.alu_ready;
                step();
            end
            n_vec++; if (!acc) begin n_err++; $display("FAIL b2b_alu_accept[%0d] got=timeout exp=accepted", i); end
        end
        bus.alu_valid = 1'b0;
    endtask

    task automatic drive_lsu3();
        for (int i = 0; i < 3; i++) begin
            logic acc = 1'b0;
            bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd4; bus.lsu_data = 32'hB1 + 32'(i);
            for (int c = 0; c < 20 && !acc; c++) begin
                acc = bus.lsu_ready;
                step();
            end
            n_vec++; if (!acc) begin n_err++; $display("FAIL b2b_lsu_accept[%0d] got=timeout exp=accepted", i); end
        end
        bus.lsu_valid = 1'b0;
    endtask

    task automatic check_b2b();
        @(posedge clk); #2;  // edge 1
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL b2b_wren_e1 got=%b exp=0", bus.rd_wren); end
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #2;  // edges 2..7, alternating ALU/LSU
            n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL b2b_wren[%0d] got=%b exp=1", i, bus.rd_wren); end
            n_vec++; if (bus.rd_addr !== ((i % 2 == 0) ? 5'd3 : 5'd4)) begin n_err++; $display("FAIL b2b_addr[%0d] got=%0d exp=%0d", i, bus.rd_addr, (i % 2 == 0) ? 3 : 4); end
            n_vec++; if (bus.rd_data !== (((i % 2 == 0) ? 32'hA1 : 32'hB1) + 32'(i / 2))) begin n_err++; $display("FAIL b2b_data[%0d] got=%h exp=%h", i, bus.rd_data, ((i % 2 == 0) ? 32'hA1 : 32'hB1) + 32'(i / 2)); end
            if (i == 0 || i == 2) begin
                n_vec++; if (bus.lsu_ready !== 1'b0) begin n_err++; $display("FAIL b2b_lsu_ready[%0d] got=%b exp=0", i, bus.lsu_ready); end
            end
            if (i == 1) begin
                n_vec++; if (bus.alu_ready !== 1'b0) begin n_err++; $display("FAIL b2b_alu_ready[%0d] got=%b exp=0", i, bus.alu_ready); end
                n_vec++; if (bus.lsu_ready !== 1'b1) begin n_err++; $display("FAIL b2b_lsu_ready[%0d] got=%b exp=1", i, bus.lsu_ready); end
            end
        end
        @(posedge clk); #2;
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL b2b_wren_end got=%b exp=0", bus.rd_wren); end
    endtask

    task automatic test_back_to_back();
        do_reset();
        fork
            drive_alu3();
            drive_lsu3();
            check_b2b();
        join
        idle_inputs();
    endtask

    task automatic test_reset_mid();
        do_reset();
        bus.issue_valid = 1'b1; bus.issue_rd = 5'd9;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd10; bus.alu_data = 32'hC1;
        bus.lsu_valid = 1'b1; bus.lsu_rd = 5'd11; bus.lsu_data = 32'hD1;
        step();
        bus.issue_valid = 1'b0;
        bus.alu_data = 32'hC2; bus.lsu_data = 32'hD2;
        step();  // three entries still queued, first write on the port
        bus.alu_valid = 1'b0; bus.lsu_valid = 1'b0;
        n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL rmid_wren_pre got=%b exp=1", bus.rd_wren); end
        n_vec++; if (bus.busy_o !== 32'h200) begin n_err++; $display("FAIL rmid_busy_pre got=%h exp=00000200", bus.busy_o); end
        #2 rst_ni = 1'b0;
        #1;
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL rmid_wren got=%b exp=0", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd0) begin n_err++; $display("FAIL rmid_addr got=%0d exp=0", bus.rd_addr); end
        n_vec++; if (bus.rd_data !== 32'd0) begin n_err++; $display("FAIL rmid_data got=%h exp=0", bus.rd_data); end
        n_vec++; if (bus.busy_o !== 32'd0) begin n_err++; $display("FAIL rmid_busy got=%h exp=0", bus.busy_o); end
        n_vec++; if (bus.alu_ready !== 1'b1) begin n_err++; $display("FAIL rmid_alu_ready got=%b exp=1", bus.alu_ready); end
        n_vec++; if (bus.lsu_ready !== 1'b1) begin n_err++; $display("FAIL rmid_lsu_ready got=%b exp=1", bus.lsu_ready); end
        step();
        rst_ni = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL rmid_no_write[%0d] got=%b exp=0", i, bus.rd_wren); end
        end
        // First transfer after release keeps the one-edge latency.
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd12; bus.alu_data = 32'hE1;
        step();
        bus.alu_valid = 1'b0;
        n_vec++; if (bus.rd_wren !== 1'b0) begin n_err++; $display("FAIL post_wren_k got=%b exp=0", bus.rd_wren); end
        step();
        n_vec++; if (bus.rd_wren !== 1'b1) begin n_err++; $display("FAIL post_wren got=%b exp=1", bus.rd_wren); end
        n_vec++; if (bus.rd_addr !== 5'd12) begin n_err++; $display("FAIL post_addr got=%0d exp=12", bus.rd_addr); end
        n_vec++; if (bus.rd_data !== 32'hE1) begin n_err++; $display("FAIL post_data got=%h exp=000000e1", bus.rd_data); end
    endtask

    initial begin
        idle_inputs();
        test_reset();
        test_single();
        test_x0();
        test_simultaneous();
        test_same_edge();
        test_back_to_back();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
